// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
// Holds the FSM state codes, trap causes, instruction classes and opcode patterns.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_TRAP    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_CBZ, C_CBNZ, C_BR, C_HLT, C_ILL
  } iclass_e;

  localparam logic [1:0] TC_NONE  = 2'b00;
  localparam logic [1:0] TC_ILL   = 2'b01;
  localparam logic [1:0] TC_MEMTO = 2'b10;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_OFS = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  // Full opcodes, and leading-bit prefixes for the wildcarded formats.
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier; anything unmatched is C_ILL with zero controls.
// ADDI is only recognised when CPU_CONTROL_MC_IMM_ALU_EN is defined.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] i_op,
  output iclass_e     o_cls,
  output logic        o_reg2loc,
  output logic        o_memtoreg,
  output logic [1:0]  o_aluop,
  output logic [1:0]  o_alusrc
);

  always_comb begin
    o_cls      = C_ILL;
    o_reg2loc  = 1'b0;
    o_memtoreg = 1'b0;
    o_aluop    = ALU_MEM;
    o_alusrc   = SRC_REG;
    if (i_op == OP_LDUR) begin
      o_cls = C_LOAD; o_alusrc = SRC_OFS; o_memtoreg = 1'b1;
    end else if (i_op == OP_STUR) begin
      o_cls = C_STORE; o_alusrc = SRC_OFS; o_reg2loc = 1'b1;
    end else if (i_op == OP_ADD || i_op == OP_SUB || i_op == OP_AND || i_op == OP_ORR) begin
      o_cls = C_RTYPE; o_aluop = ALU_R;
`ifdef CPU_CONTROL_MC_IMM_ALU_EN
    end else if (i_op[10:1] == OP_ADDI) begin
      o_cls = C_ITYPE; o_aluop = ALU_R; o_alusrc = SRC_IMM;
`endif
    end else if (i_op[10:3] == OP_CBZ) begin
      o_cls = C_CBZ; o_aluop = ALU_BR; o_reg2loc = 1'b1;
    end else if (i_op[10:3] == OP_CBNZ) begin
      o_cls = C_CBNZ; o_aluop = ALU_BR; o_reg2loc = 1'b1;
    end else if (i_op[10:5] == OP_B) begin
      o_cls = C_BR;
    end else if (i_op == OP_HALT) begin
      o_cls = C_HLT;
    end
  end

endmodule

// File: rtl/cpu_control_mc.sv
// Multi-cycle control FSM with memory-wait timeout, sticky halt/trap and retire counter.
// Optional ADDI support: define CPU_CONTROL_MC_IMM_ALU_EN.
module cpu_control_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      inst31_21,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             Reg2Loc,
  output logic             Branch,
  output logic             BranchZero,
  output logic             BranchNonZero,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrc,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  state_e           r_state, w_next;
  iclass_e          r_cls, w_dec_cls;
  logic             r_reg2loc, r_memtoreg, w_dec_reg2loc, w_dec_memtoreg;
  logic [1:0]       r_aluop, r_alusrc, w_dec_aluop, w_dec_alusrc;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_wait;
  logic             w_last, w_retire, w_trap_ill, w_trap_to;
  logic             w_mr, w_mw, w_rw, w_pw, w_iw, w_b, w_bz, w_bnz;

  cpu_ctrl_decode u_dec (
    .i_op      (inst31_21),
    .o_cls     (w_dec_cls),
    .o_reg2loc (w_dec_reg2loc),
    .o_memtoreg(w_dec_memtoreg),
    .o_aluop   (w_dec_aluop),
    .o_alusrc  (w_dec_alusrc)
  );

  // Final allowed wait cycle; a ready seen here still completes the access.
  assign w_last = (r_wait == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_retire = 1'b0; w_trap_ill = 1'b0; w_trap_to = 1'b0;
    w_mr = 1'b0; w_mw = 1'b0; w_rw = 1'b0; w_pw = 1'b0;
    w_iw = 1'b0; w_b = 1'b0; w_bz = 1'b0; w_bnz = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mr = 1'b1;
        if (mem_ready) begin
          w_iw = 1'b1; w_pw = 1'b1; w_next = S_DECODE;
        end else if (w_last) begin
          w_trap_to = 1'b1; w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        if (w_dec_cls == C_ILL) begin
          w_trap_ill = 1'b1; w_next = S_TRAP;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (r_cls)
          C_RTYPE, C_ITYPE: w_next = S_WB;
          C_LOAD, C_STORE:  w_next = S_MEM;
          C_CBZ:  begin w_bz  = 1'b1; w_pw = zero;  w_retire = 1'b1; w_next = S_FETCH; end
          C_CBNZ: begin w_bnz = 1'b1; w_pw = ~zero; w_retire = 1'b1; w_next = S_FETCH; end
          C_BR:   begin w_b   = 1'b1; w_pw = 1'b1;  w_retire = 1'b1; w_next = S_FETCH; end
          C_HLT:  begin w_retire = 1'b1; w_next = S_HALT; end
          default: begin w_trap_ill = 1'b1; w_next = S_TRAP; end
        endcase
      end
      S_MEM: begin
        w_mw = (r_cls == C_STORE);
        w_mr = (r_cls != C_STORE);
        if (mem_ready) begin
          w_retire = (r_cls == C_STORE);
          w_next   = (r_cls == C_STORE) ? S_FETCH : S_WB;
        end else if (w_last) begin
          w_trap_to = 1'b1; w_next = S_TRAP;
        end
      end
      S_WB: begin
        w_rw = 1'b1; w_retire = 1'b1; w_next = S_FETCH;
      end
      S_HALT, S_TRAP: w_next = r_state;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_cls      <= C_ILL;
      r_reg2loc  <= 1'b0;
      r_memtoreg <= 1'b0;
      r_aluop    <= ALU_MEM;
      r_alusrc   <= SRC_REG;
      r_cause    <= TC_NONE;
      r_cnt      <= '0;
      r_wait     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls      <= w_dec_cls;
        r_reg2loc  <= w_dec_reg2loc;
        r_memtoreg <= w_dec_memtoreg;
        r_aluop    <= w_dec_aluop;
        r_alusrc   <= w_dec_alusrc;
      end
      if (w_trap_ill) r_cause <= TC_ILL;
      if (w_trap_to)  r_cause <= TC_MEMTO;
      if (w_retire)   r_cnt   <= r_cnt + CNT_W'(1);
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + 8'd1;
    end
  end

  // 1-bit outputs read as 0 while reset is held, whatever state is registered.
  assign MemRead       = w_mr  & ~reset;
  assign MemWrite      = w_mw  & ~reset;
  assign RegWrite      = w_rw  & ~reset;
  assign PCWrite       = w_pw  & ~reset;
  assign IRWrite       = w_iw  & ~reset;
  assign Branch        = w_b   & ~reset;
  assign BranchZero    = w_bz  & ~reset;
  assign BranchNonZero = w_bnz & ~reset;
  assign halted        = (r_state == S_HALT) & ~reset;
  assign trap          = (r_state == S_TRAP) & ~reset;
  assign Reg2Loc       = r_reg2loc  & ~reset;
  assign MemtoReg      = r_memtoreg & ~reset;
  assign ALUOp         = r_aluop;
  assign ALUSrc        = r_alusrc;
  assign trap_cause    = r_cause;
  assign instr_count   = r_cnt;
  assign state         = r_state;

endmodule
